// File: rtl/lsu_riscv.sv
// Load/store unit: turns execute-stage memory requests into byte-enabled
// grant/valid transactions, stalls the core until completion, extends load data.
module lsu_riscv #(
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              lsu_req_i,
    input  logic              lsu_we_i,
    input  logic [2:0]        lsu_size_i,
    input  logic [ADDR_W-1:0] lsu_addr_i,
    input  logic [31:0]       lsu_data_i,
    output logic [31:0]       lsu_data_o,
    output logic              lsu_stall_req_o,
    output logic              lsu_misalign_o,
    output logic              data_req_o,
    output logic              data_we_o,
    output logic [3:0]        data_be_o,
    output logic [ADDR_W-1:0] data_addr_o,
    output logic [31:0]       data_wdata_o,
    input  logic              data_gnt_i,
    input  logic              data_rvalid_i,
    input  logic [31:0]       data_rdata_i
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic              r_we;
    logic [2:0]        r_size;
    logic [1:0]        r_off;
    logic [ADDR_W-1:0] r_addr;
    logic [3:0]        r_be;
    logic [31:0]       r_wdata;
    logic [31:0]       r_ldata;

    logic              w_legal;
    logic [3:0]        w_be;
    logic [31:0]       w_wdata;
    logic              w_idle_req;
    logic              w_accept;
    logic              w_done;
    logic [7:0]        w_byte;
    logic [15:0]       w_half;
    logic [31:0]       w_ext;

    // Request decode: legality, lane enables and replicated store data
    always_comb begin
        w_legal = 1'b0;
        w_be    = 4'b0000;
        w_wdata = 32'h0;
        case (lsu_size_i)
            3'd0, 3'd4: begin
                w_legal = 1'b1;
                w_be    = 4'(4'b0001 << lsu_addr_i[1:0]);
                w_wdata = {4{lsu_data_i[7:0]}};
            end
            3'd1, 3'd5: begin
                w_legal = ~lsu_addr_i[0];
                w_be    = 4'(4'b0011 << lsu_addr_i[1:0]);
                w_wdata = {2{lsu_data_i[15:0]}};
            end
            3'd2: begin
                w_legal = (lsu_addr_i[1:0] == 2'b00);
                w_be    = 4'b1111;
                w_wdata = lsu_data_i;
            end
            default: ;
        endcase
    end

    assign w_idle_req = ~rst_i & (r_state == S_IDLE) & lsu_req_i;
    assign w_accept   = w_idle_req & w_legal;
    assign w_done     = (r_state == S_RESP) & data_rvalid_i;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept)      w_state_nxt = S_REQ;
            S_REQ:   if (data_gnt_i)    w_state_nxt = S_RESP;
            S_RESP:  if (data_rvalid_i) w_state_nxt = S_IDLE;
            default:                    w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Lane selection uses the offset captured at acceptance
    always_comb begin
        w_byte = 8'(data_rdata_i >> {r_off, 3'b000});
        w_half = r_off[1] ? data_rdata_i[31:16] : data_rdata_i[15:0];
        case (r_size)
            3'd0:    w_ext = {{24{w_byte[7]}}, w_byte};
            3'd4:    w_ext = {24'h0, w_byte};
            3'd1:    w_ext = {{16{w_half[15]}}, w_half};
            3'd5:    w_ext = {16'h0, w_half};
            default: w_ext = data_rdata_i;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_we    <= 1'b0;
            r_size  <= 3'd0;
            r_off   <= 2'd0;
            r_addr  <= '0;
            r_be    <= 4'b0000;
            r_wdata <= 32'h0;
            r_ldata <= 32'h0;
        end else begin
            if (w_accept) begin
                r_we    <= lsu_we_i;
                r_size  <= lsu_size_i;
                r_off   <= lsu_addr_i[1:0];
                r_addr  <= {lsu_addr_i[ADDR_W-1:2], 2'b00};
                r_be    <= w_be;
                r_wdata <= w_wdata;
            end
            if (w_done && !r_we) begin
                r_ldata <= w_ext;
            end
        end
    end

    assign data_req_o      = (r_state == S_REQ);
    assign data_we_o       = r_we;
    assign data_be_o       = r_be;
    assign data_addr_o     = r_addr;
    assign data_wdata_o    = r_wdata;
    assign lsu_data_o      = (w_done && !r_we) ? w_ext : r_ldata;
    assign lsu_misalign_o  = w_idle_req & ~w_legal;
    assign lsu_stall_req_o = ~rst_i & (w_accept | (r_state == S_REQ) |
                                       ((r_state == S_RESP) & ~data_rvalid_i));

endmodule
